// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared constants, types and helpers for the memory-access stage.
//   - load/store opcode values (Ins[31:26])
//   - FSM state type and access-size type
//   - op_size / op_is_load decode helpers
package mem_access_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } size_t;

  // Access size of an opcode; SZ_NONE marks a non-memory instruction.
  function automatic size_t op_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
      OP_LW, OP_SW:         op_size = SZ_WORD;
      default:              op_size = SZ_NONE;
    endcase
  endfunction

  function automatic logic op_is_load(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: op_is_load = 1'b1;
      default:                             op_is_load = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// load_align: combinational lane extraction and extension of bus read data.
//   mrdata  in  32  raw word returned by the data bus
//   addr    in  2   byte offset of the access within the word
//   op      in  6   load opcode (selects width and sign/zero extension)
//   data    out 32  extended load value (0 for non-load opcodes)
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] mrdata,
  input  logic [1:0]  addr,
  input  logic [5:0]  op,
  output logic [31:0] data
);

  logic [31:0] shifted_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte / half-word lane and extend it per opcode.
  always_comb begin
    shifted_s = mrdata >> {addr, 3'b000};
    byte_s    = shifted_s[7:0];
    half_s    = addr[1] ? mrdata[31:16] : mrdata[15:0];
    case (op)
      OP_LB:   data = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  data = {24'h000000, byte_s};
      OP_LH:   data = {{16{half_s[15]}}, half_s};
      OP_LHU:  data = {16'h0000, half_s};
      OP_LW:   data = mrdata;
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: MIPS memory-access stage with a req/ack data-memory bus.
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   in_valid/Ins/Result/Rdata2  instruction, ALU result (address), store data
//   Stall               combinational hold request to the upstream stage
//   out_valid/WBData    one-cycle result pulse and write-back value
//   addr_err/bus_err    misalignment / ack-timeout flags, qualified by out_valid
//   mreq/mwe/maddr/mbe/mwdata  registered bus request fields
//   mrdata/mack         bus read data and single-cycle acknowledge
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  output logic        Stall,
  output logic        out_valid,
  output logic [31:0] WBData,
  output logic        addr_err,
  output logic        bus_err,
  output logic        mreq,
  output logic        mwe,
  output logic [29:0] maddr,
  output logic [3:0]  mbe,
  output logic [31:0] mwdata,
  input  logic [31:0] mrdata,
  input  logic        mack
);

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        mreq_q, mreq_d, mwe_q, mwe_d;
  logic [29:0] maddr_q, maddr_d;
  logic [3:0]  mbe_q, mbe_d;
  logic [31:0] mwdata_q, mwdata_d;
  logic [5:0]  op_q, op_d;
  logic [1:0]  alo_q, alo_d;
  logic        out_valid_q, out_valid_d, addr_err_q, addr_err_d, bus_err_q, bus_err_d;
  logic [31:0] wbdata_q, wbdata_d;

  logic [5:0]  op_s;
  size_t       size_s;
  logic        misalign_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;
  logic        timeout_hit_s;
  logic [31:0] load_data_s;
  logic        unused_s;

  assign op_s     = Ins[31:26];
  assign size_s   = op_size(op_s);
  assign unused_s = ^Ins[25:0];

  // Alignment check, byte enables and lane-replicated store data for the incoming op.
  always_comb begin
    misalign_s = 1'b0;
    be_s       = 4'b0000;
    wdata_s    = 32'h0000_0000;
    case (size_s)
      SZ_BYTE: begin
        be_s    = 4'b0001 << Result[1:0];
        wdata_s = {4{Rdata2[7:0]}};
      end
      SZ_HALF: begin
        misalign_s = Result[0];
        be_s       = Result[1] ? 4'b1100 : 4'b0011;
        wdata_s    = {2{Rdata2[15:0]}};
      end
      SZ_WORD: begin
        misalign_s = |Result[1:0];
        be_s       = 4'b1111;
        wdata_s    = Rdata2;
      end
      default: begin
        misalign_s = 1'b0;
      end
    endcase
    if (op_is_load(op_s)) begin
      wdata_s = 32'h0000_0000;
    end else begin
      wdata_s = wdata_s;
    end
  end

  // The limit cycle only counts as a timeout when mack does not arrive in it.
  assign timeout_hit_s = (ACK_TIMEOUT != 32'd0) && (state_q == ST_WAIT) &&
                         (cnt_q == CNT_W'(ACK_TIMEOUT - 32'd1)) && !mack;

  load_align u_load_align (
    .mrdata (mrdata),
    .addr   (alo_q),
    .op     (op_q),
    .data   (load_data_s)
  );

  // Next-state, bus-field and result computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mreq_d      = mreq_q;
    mwe_d       = mwe_q;
    maddr_d     = maddr_q;
    mbe_d       = mbe_q;
    mwdata_d    = mwdata_q;
    op_d        = op_q;
    alo_d       = alo_q;
    out_valid_d = 1'b0;
    addr_err_d  = 1'b0;
    bus_err_d   = 1'b0;
    wbdata_d    = wbdata_q;
    Stall       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (size_s == SZ_NONE) begin
            out_valid_d = 1'b1;
            wbdata_d    = Result;
          end else if (misalign_s) begin
            out_valid_d = 1'b1;
            addr_err_d  = 1'b1;
            wbdata_d    = Result;
          end else begin
            Stall    = 1'b1;
            mreq_d   = 1'b1;
            mwe_d    = !op_is_load(op_s);
            maddr_d  = Result[31:2];
            mbe_d    = be_s;
            mwdata_d = wdata_s;
            op_d     = op_s;
            alo_d    = Result[1:0];
            cnt_d    = {CNT_W{1'b0}};
            state_d  = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mack) begin
          mreq_d      = 1'b0;
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          wbdata_d    = op_is_load(op_q) ? load_data_s : 32'h0000_0000;
        end else if (timeout_hit_s) begin
          mreq_d      = 1'b0;
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          bus_err_d   = 1'b1;
          wbdata_d    = 32'h0000_0000;
        end else begin
          Stall = 1'b1;
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      mreq_q      <= 1'b0;
      mwe_q       <= 1'b0;
      maddr_q     <= 30'd0;
      mbe_q       <= 4'b0000;
      mwdata_q    <= 32'h0000_0000;
      op_q        <= 6'h00;
      alo_q       <= 2'b00;
      out_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      wbdata_q    <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mreq_q      <= mreq_d;
      mwe_q       <= mwe_d;
      maddr_q     <= maddr_d;
      mbe_q       <= mbe_d;
      mwdata_q    <= mwdata_d;
      op_q        <= op_d;
      alo_q       <= alo_d;
      out_valid_q <= out_valid_d;
      addr_err_q  <= addr_err_d;
      bus_err_q   <= bus_err_d;
      wbdata_q    <= wbdata_d;
    end
  end

  assign mreq      = mreq_q;
  assign mwe       = mwe_q;
  assign maddr     = maddr_q;
  assign mbe       = mbe_q;
  assign mwdata    = mwdata_q;
  assign out_valid = out_valid_q;
  assign addr_err  = addr_err_q;
  assign bus_err   = bus_err_q;
  assign WBData    = wbdata_q;

endmodule
